// File: rtl/decode_stage.sv
// Purpose: RV32/RV64 integer decode stage; one 32-bit instruction per cycle into a
//          normalised control word held in a two-entry (main + skid) output buffer.
// Latency: 1 cycle from accept to presentation when main is empty or draining.
// Backpressure: valid/ready on both sides; in_ready is a flop and drops only when
//               the skid entry is occupied, so out_ready has no combinational path to it.
// Ports:
//   clk, rst            sole clock, synchronous active-high reset
//   flush               kills both buffered words and any same-cycle accept
//   in_valid/in_ready   fetch-side handshake for in_inst/in_pc
//   out_valid/out_ready issue-side handshake for the out_* decoded fields
//   out_unit            00 none/illegal, 01 ALU, 10 MEM, 11 FENCE
//   out_alu_op/out_word/out_mem_op/out_rd*/out_rs*/out_imm/out_fence_*/out_illegal
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [1:0]      out_unit,
  output logic [3:0]      out_alu_op,
  output logic            out_word,
  output logic [3:0]      out_mem_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_fence_pred,
  output logic [3:0]      out_fence_succ,
  output logic            out_illegal
);

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [1:0] UNIT_NONE  = 2'b00;
  localparam logic [1:0] UNIT_ALU   = 2'b01;
  localparam logic [1:0] UNIT_MEM   = 2'b10;
  localparam logic [1:0] UNIT_FENCE = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [1:0]      unit;
    logic [3:0]      alu_op;
    logic            word;
    logic [3:0]      mem_op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic [3:0]      fence_pred;
    logic [3:0]      fence_succ;
    logic            illegal;
  } dec_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the offered instruction
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u_raw;
  logic [XLEN-1:0] imm_u;
  logic            f7_zero;
  logic            f7_alt;

  assign opcode  = in_inst[6:0];
  assign rd      = in_inst[11:7];
  assign funct3  = in_inst[14:12];
  assign rs1     = in_inst[19:15];
  assign rs2     = in_inst[24:20];
  assign funct7  = in_inst[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  // Sign-extend the 20-bit field first, then shift: yields {sext, inst[31:12], 12'b0}
  // for either XLEN without a zero-width replication at XLEN=32.
  assign imm_u_raw = {{(XLEN-20){in_inst[31]}}, in_inst[31:12]};
  assign imm_u     = imm_u_raw << 12;

  dec_t dec;
  logic legal;

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    legal      = 1'b0;

    case (opcode)
      OPC_OP_IMM: begin
        dec.unit   = UNIT_ALU;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.rd_we  = (rd != 5'd0);
        dec.imm    = imm_i;
        dec.alu_op = {(funct3 == 3'b101) & in_inst[30], funct3};
        case (funct3)
          // RV64 shamt is 6 bits, so inst[25] belongs to the shift amount there.
          3'b001:  legal = IS_RV64 ? (in_inst[31:26] == 6'b000000) : f7_zero;
          3'b101:  legal = IS_RV64 ? (in_inst[31:26] == 6'b000000 || in_inst[31:26] == 6'b010000)
                                   : (f7_zero || f7_alt);
          default: legal = 1'b1;
        endcase
      end

      OPC_OP_IMM_32: begin
        dec.unit   = UNIT_ALU;
        dec.word   = 1'b1;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.rd_we  = (rd != 5'd0);
        dec.imm    = imm_i;
        dec.alu_op = {(funct3 == 3'b101) & in_inst[30], funct3};
        case (funct3)
          3'b000:  legal = IS_RV64;
          3'b001:  legal = IS_RV64 && f7_zero;
          3'b101:  legal = IS_RV64 && (f7_zero || f7_alt);
          default: legal = 1'b0;
        endcase
      end

      OPC_OP: begin
        dec.unit   = UNIT_ALU;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.rd_we  = (rd != 5'd0);
        dec.alu_op = {in_inst[30], funct3};
        legal      = f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
      end

      OPC_OP_32: begin
        dec.unit   = UNIT_ALU;
        dec.word   = 1'b1;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.rd_we  = (rd != 5'd0);
        dec.alu_op = {in_inst[30], funct3};
        // Only ADDW/SUBW, SLLW, SRLW/SRAW exist; SUB/SRA-style alt only on 000/101.
        case (funct3)
          3'b000, 3'b101: legal = IS_RV64 && (f7_zero || f7_alt);
          3'b001:         legal = IS_RV64 && f7_zero;
          default:        legal = 1'b0;
        endcase
      end

      OPC_LUI: begin
        dec.unit   = UNIT_ALU;
        dec.rd     = rd;
        dec.rd_we  = (rd != 5'd0);
        dec.imm    = imm_u;
        dec.alu_op = 4'b0000;
        legal      = 1'b1;
      end

      OPC_AUIPC: begin
        // Downstream adds the carried PC to imm; no source register.
        dec.unit   = UNIT_ALU;
        dec.rd     = rd;
        dec.rd_we  = (rd != 5'd0);
        dec.imm    = imm_u;
        dec.alu_op = 4'b1000;
        legal      = 1'b1;
      end

      OPC_LOAD: begin
        dec.unit   = UNIT_MEM;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.rd_we  = (rd != 5'd0);
        dec.imm    = imm_i;
        dec.mem_op = {1'b0, funct3};
        case (funct3)
          3'b011, 3'b110: legal = IS_RV64;
          3'b111:         legal = 1'b0;
          default:        legal = 1'b1;
        endcase
      end

      OPC_STORE: begin
        dec.unit   = UNIT_MEM;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.imm    = imm_s;
        dec.mem_op = {1'b1, funct3};
        case (funct3)
          3'b000, 3'b001, 3'b010: legal = 1'b1;
          3'b011:                 legal = IS_RV64;
          default:                legal = 1'b0;
        endcase
      end

      OPC_MISC_MEM: begin
        dec.unit = UNIT_FENCE;
        dec.imm  = imm_i;
        if (funct3 == 3'b000) begin
          dec.fence_pred = in_inst[27:24];
          dec.fence_succ = in_inst[23:20];
        end
        // Reserved fence fields (fm, rd, rs1) must be zero.
        legal = (funct3 == 3'b000 || funct3 == 3'b001) &&
                (rd == 5'd0) && (rs1 == 5'd0) && (in_inst[31:28] == 4'b0000);
      end

      // Unknown opcodes, and any encoding with inst[1:0] != 11, land here.
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec.unit       = UNIT_NONE;
      dec.rd_we      = 1'b0;
      dec.alu_op     = 4'b0000;
      dec.mem_op     = 4'b0000;
      dec.word       = 1'b0;
      dec.imm        = '0;
      dec.fence_pred = 4'b0000;
      dec.fence_succ = 4'b0000;
      dec.illegal    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry output buffer (main presented, skid behind it)
  // ---------------------------------------------------------------------------
  dec_t main_q, main_d;
  dec_t skid_q, skid_d;
  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic in_rdy_q, in_rdy_d;
  logic accept;
  logic drain;

  // in_rdy_q always mirrors !skid_vld_q, so an accept implies the skid is free.
  assign accept = in_valid && in_rdy_q;
  assign drain  = main_vld_q && out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;

    if (drain) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = 1'b0;
      end
    end

    if (accept) begin
      if (!main_vld_q || drain) begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end
    end

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end

    // Keeps every output field at zero while nothing is presented.
    if (!main_vld_d) begin
      main_d = '0;
    end

    in_rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_ready       = in_rdy_q;
  assign out_valid      = main_vld_q;
  assign out_pc         = main_q.pc;
  assign out_unit       = main_q.unit;
  assign out_alu_op     = main_q.alu_op;
  assign out_word       = main_q.word;
  assign out_mem_op     = main_q.mem_op;
  assign out_rd         = main_q.rd;
  assign out_rs1        = main_q.rs1;
  assign out_rs2        = main_q.rs2;
  assign out_rd_we      = main_q.rd_we;
  assign out_imm        = main_q.imm;
  assign out_fence_pred = main_q.fence_pred;
  assign out_fence_succ = main_q.fence_succ;
  assign out_illegal    = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Purpose: directed self-checking bench for decode_stage at XLEN=32 and XLEN=64 side by side.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: out_ready toggled by the stimulus to fill, hold, drain and flush the buffer.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        r32, v32, w32, rdwe32, ill32;
  logic [31:0] pc32, imm32;
  logic [1:0]  unit32;
  logic [3:0]  alu32, mem32, pred32, succ32;
  logic [4:0]  rd32, rs1_32, rs2_32;

  logic        r64, v64, w64, rdwe64, ill64;
  logic [63:0] pc64, imm64;
  logic [1:0]  unit64;
  logic [3:0]  alu64, mem64, pred64, succ64;
  logic [4:0]  rd64, rs1_64, rs2_64;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_pc(pc32), .out_unit(unit32), .out_alu_op(alu32), .out_word(w32),
    .out_mem_op(mem32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_rd_we(rdwe32), .out_imm(imm32), .out_fence_pred(pred32),
    .out_fence_succ(succ32), .out_illegal(ill32)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
    .out_pc(pc64), .out_unit(unit64), .out_alu_op(alu64), .out_word(w64),
    .out_mem_op(mem64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_rd_we(rdwe64), .out_imm(imm64), .out_fence_pred(pred64),
    .out_fence_succ(succ64), .out_illegal(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for exactly one edge, then withdraw it.
  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    in_inst  = inst;
    in_pc    = pc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_vld32", v32, 0);
    chk("rst_rdy32", r32, 1);
    chk("rst_unit32", unit32, 0);
    chk("rst_imm32", imm32, 0);
    chk("rst_vld64", v64, 0);
    chk("rst_rdy64", r64, 1);
    chk("rst_imm64", imm64, 0);

    // Streaming ADDI x1,x0,-1 then ADDI x2,x1,5 back to back
    rst = 1'b0;
    in_inst = 32'hFFF00093; in_pc = 64'h100; in_valid = 1'b1;
    step();
    chk("addi_vld", v32, 1);
    chk("addi_unit", unit32, 1);
    chk("addi_alu", alu32, 0);
    chk("addi_rd", rd32, 1);
    chk("addi_rdwe", rdwe32, 1);
    chk("addi_imm32", imm32, 32'hFFFFFFFF);
    chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("addi_pc", pc32, 32'h100);
    chk("addi_ill", ill32, 0);
    in_inst = 32'h00508113; in_pc = 64'h104;
    step();
    in_valid = 1'b0;
    chk("addi2_vld", v32, 1);
    chk("addi2_rd", rd32, 2);
    chk("addi2_rs1", rs1_32, 1);
    chk("addi2_imm", imm32, 5);
    chk("addi2_pc", pc32, 32'h104);
    chk("stream_rdy", r32, 1);
    step();
    chk("drained_vld", v32, 0);
    chk("drained_rd", rd32, 0);

    // Backpressure: A, B fill the buffer, C is refused until a drain
    out_ready = 1'b0;
    in_inst = 32'h00100193; in_pc = 64'h200; in_valid = 1'b1;
    step();
    chk("bp_a_vld", v32, 1);
    chk("bp_a_rdy", r32, 1);
    in_inst = 32'h00200213; in_pc = 64'h204;
    step();
    chk("bp_full_rdy", r32, 0);
    chk("bp_hold_rd1", rd32, 3);
    in_inst = 32'h00300293; in_pc = 64'h208;
    step();
    chk("bp_full_rdy2", r32, 0);
    chk("bp_hold_rd2", rd32, 3);
    chk("bp_hold_pc", pc32, 32'h200);
    step();
    chk("bp_hold_rd3", rd32, 3);
    out_ready = 1'b1;
    step();
    chk("bp_b_rd", rd32, 4);
    chk("bp_b_pc", pc32, 32'h204);
    chk("bp_rdy_back", r32, 1);
    step();
    in_valid = 1'b0;
    chk("bp_c_vld", v32, 1);
    chk("bp_c_rd", rd32, 5);
    chk("bp_c_rdy", r32, 1);
    step();
    chk("bp_empty", v32, 0);

    // RV64-only encodings
    send(32'h00003003, 64'h300);                      // LD x0,0(x0)
    chk("ld_ill32", ill32, 1);
    chk("ld_unit32", unit32, 0);
    chk("ld_ill64", ill64, 0);
    chk("ld_unit64", unit64, 2);
    chk("ld_mem64", mem64, 4'b0011);
    chk("ld_pc32", pc32, 32'h300);
    send(32'h0000003B, 64'h304);                      // ADDW x0,x0,x0
    chk("addw_ill32", ill32, 1);
    chk("addw_unit32", unit32, 0);
    chk("addw_ill64", ill64, 0);
    chk("addw_word64", w64, 1);
    chk("addw_unit64", unit64, 1);
    send(32'h00006083, 64'h308);                      // LWU x1,0(x0)
    chk("lwu_ill64", ill64, 0);
    chk("lwu_mem64", mem64, 4'b0110);
    chk("lwu_rdwe64", rdwe64, 1);
    chk("lwu_ill32", ill32, 1);
    chk("lwu_rdwe32", rdwe32, 0);
    send(32'h00007083, 64'h30C);                      // LOAD funct3 111
    chk("ld111_ill32", ill32, 1);
    chk("ld111_ill64", ill64, 1);
    chk("ld111_vld", v64, 1);

    // SRAI x1,x1,33
    send(32'h4210D093, 64'h310);
    chk("srai_alu64", alu64, 4'b1101);
    chk("srai_ill64", ill64, 0);
    chk("srai_imm64", imm64, 64'h421);
    chk("srai_ill32", ill32, 1);
    chk("srai_alu32", alu32, 0);

    // FENCE rw,rw and a malformed one with rd=1
    send(32'h0330000F, 64'h314);
    chk("fence_unit", unit32, 3);
    chk("fence_pred", pred32, 4'b0011);
    chk("fence_succ", succ64, 4'b0011);
    chk("fence_rdwe", rdwe32, 0);
    chk("fence_ill", ill32, 0);
    send(32'h0330008F, 64'h318);
    chk("fence_rd_ill", ill32, 1);
    chk("fence_rd_unit", unit32, 0);
    chk("fence_rd_pred", pred32, 0);

    // STORE, LUI, OP
    send(32'h0020A423, 64'h31C);                      // SW x2,8(x1)
    chk("sw_unit", unit32, 2);
    chk("sw_mem", mem32, 4'b1010);
    chk("sw_imm", imm32, 8);
    chk("sw_rs1", rs1_32, 1);
    chk("sw_rs2", rs2_32, 2);
    chk("sw_rd", rd32, 0);
    chk("sw_rdwe", rdwe32, 0);
    send(32'h800000B7, 64'h320);                      // LUI x1,0x80000
    chk("lui_imm32", imm32, 32'h80000000);
    chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    chk("lui_unit", unit64, 1);
    chk("lui_rs1", rs1_32, 0);
    send(32'h00000097, 64'h324);                      // AUIPC x1,0
    chk("auipc_alu", alu32, 4'b1000);
    send(32'h403100B3, 64'h328);                      // SUB x1,x2,x3
    chk("sub_alu", alu32, 4'b1000);
    chk("sub_rs2", rs2_32, 3);
    send(32'h403110B3, 64'h32C);                      // funct7 0100000 with funct3 001
    chk("op_bad_ill", ill32, 1);
    send(32'h00000093 & 32'hFFFFFFFC, 64'h330);       // inst[1:0] = 00
    chk("low_bits_ill", ill64, 1);
    step();
    chk("dec_empty", v32, 0);

    // Flush with both entries full while a word is offered
    out_ready = 1'b0;
    send(32'h00100193, 64'h400);
    send(32'h00200213, 64'h404);
    chk("fl_full_rdy", r32, 0);
    in_inst = 32'h00300293; in_pc = 64'h408; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld", v32, 0);
    chk("fl_rdy", r32, 1);
    chk("fl_rd", rd32, 0);
    out_ready = 1'b1;
    step();
    chk("fl_after_vld", v32, 0);

    // Flush with one entry and a concurrent accept
    out_ready = 1'b0;
    send(32'h00100193, 64'h500);
    in_inst = 32'h00200213; in_pc = 64'h504; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_vld", v64, 0);
    chk("fl1_rdy", r64, 1);
    step();
    chk("fl1_after_vld", v64, 0);

    // Reset with one entry held and a concurrent accept
    send(32'h00100193, 64'h600);
    chk("rs_pre_vld", v32, 1);
    in_inst = 32'h00200213; in_pc = 64'h604; in_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rs_vld", v32, 0);
    chk("rs_rdy", r32, 1);
    chk("rs_pc", pc32, 0);
    out_ready = 1'b1;
    step();
    chk("rs_after_vld", v32, 0);
    chk("rs_after_vld64", v64, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised RV32/RV64 integer decode stage sitting between the fetch queue and the issue/register-read stage of the Nebula core. It decodes one 32-bit instruction per cycle into a normalised control word. The decoded word is held in a two-entry output buffer (main + skid) under valid/ready handshakes on both sides, so throughput is full and `in_ready` is registered. It adds what the single-cycle decoder lacks: XLEN parametrisation, backpressure, pipeline flush, PC pass-through, and STORE/LUI/AUIPC/OP_32/OP_IMM_32 decode.

## Interface
- `XLEN`, 32: datapath width. Only 32 or 64 is legal. 64 enables RV64I-only encodings.
- `clk` in 1: sole clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous pipeline kill. Empties the buffer.
- `in_valid` in 1: the fetch side offers `in_inst`/`in_pc`.
- `in_ready` out 1: the stage accepts the offer this cycle. Registered.
- `in_inst` in 32: raw instruction.
- `in_pc` in XLEN: instruction address.
- `out_valid` out 1: the decoded word is presented.
- `out_ready` in 1: the consumer accepts the word this cycle.
- `out_pc` out XLEN: PC of the presented word.
- `out_unit` out 2: 00 none/illegal, 01 ALU, 10 MEM, 11 FENCE.
- `out_alu_op` out 4: {alt, funct3}. alt is inst[30] for OP/OP_32 and for shift-right immediates, and 0 otherwise.
- `out_word` out 1: the instruction is an OP_32/OP_IMM_32 (W-suffix) operation.
- `out_mem_op` out 4: {is_store, funct3} for LOAD/STORE. 0 otherwise.
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: register indices. Each is forced to 0 when unused.
- `out_rd_we` out 1: the instruction writes `rd`. Forced to 0 when rd==0.
- `out_imm` out XLEN: decoded immediate, sign-extended to XLEN.
- `out_fence_pred`, `out_fence_succ` out 4 each: FENCE ordering sets.
- `out_illegal` out 1: the instruction is illegal or unsupported.

## Operation
- **Instruction formats** (opcode[6:0]):
  - OP_IMM, OP_IMM_32, LOAD, MISC_MEM: I-type.
  - STORE: S-type.
  - LUI, AUIPC: U-type; imm = {inst[31:12], 12'b0}, sign-extended.
  - OP, OP_32: R-type; imm = 0.
- **LUI and AUIPC**: both decode as ALU ops. LUI: alu_op 0000, rs1 = 0. AUIPC: alu_op 1000, rs1 = 0, with the PC consumed downstream.
- **OP legality**: funct7 = 0000000 is legal for every funct3. funct7 = 0100000 is legal only with funct3 000 or 101. Anything else is illegal.
- **OP_IMM shifts**:
  - XLEN=32: inst[31:25] must be 0000000, or 0100000 for SRAI only.
  - XLEN=64: inst[31:26] must be 000000, or 010000 for SRAI only.
  - `out_imm` carries the raw sign-extended I-immediate; the shamt is taken downstream.
- **OP_32 / OP_IMM_32**:
  - Illegal when XLEN=32.
  - OP_32 legal funct3: 000 (ADDW/SUBW), 001, 101.
  - OP_IMM_32 legal funct3: 000, 001, 101. Shifts require inst[31:25] = 0000000, or 0100000 for SRAIW.
- **LOAD**:
  - funct3 000/001/010/100/101 are legal.
  - 011 and 110 are legal only when XLEN=64.
  - 111 is illegal.
- **STORE**: funct3 000/001/010 are legal. 011 is legal only when XLEN=64. Anything else is illegal.
- **MISC_MEM**:
  - Requires rd = 0, rs1 = 0, and inst[31:28] = 0.
  - FENCE (funct3 000): pred = inst[27:24], succ = inst[23:20].
  - FENCE.I (funct3 001): pred = succ = 0.
  - `out_unit` = 11, `out_rd_we` = 0.
- **Global legality**: inst[1:0] ≠ 11 is illegal, and so is any opcode not listed above.
- **Illegal word**: an illegal instruction still produces a valid output word with `out_illegal` = 1, `out_unit` = 00, and rd_we/alu_op/mem_op/word/imm/fence fields all 0. `out_pc` is kept for the trap.
- **Buffer**:
  - Holds up to two entries, main (presented) and skid.
  - Accept: `in_valid && in_ready`. The word is decoded combinationally and written at the edge into main if main is empty or draining, otherwise into skid.
  - Drain: `out_valid && out_ready`. The skid entry moves to main.
  - `in_ready` (next) = skid empty after the edge's updates.
  - Order is strictly FIFO.
- **Flush** (priority over everything except `rst`): both entries are invalidated at the edge and an accept in the same cycle is discarded. `in_ready` = 1 next cycle.
- **Reset**: `rst` = 1 at an edge empties both entries, including mid-transfer.

## Timing
- Latency: accept at edge N puts the word on the outputs at N+1 when main was empty or draining.
- Throughput: 1/cycle while `out_ready` = 1.
- `in_ready` depends only on flops; no combinational path from `out_ready`.
- A word in main and its outputs stay stable while `out_valid && !out_ready`.
- Reset values:
  - `out_valid` = 0, `in_ready` = 1.
  - All other outputs 0.
  - Output fields are also zeroed whenever main is empty.
- **Boundary conditions**:
  - Both entries full with `out_ready` = 0: `in_ready` = 0 and input is ignored.
  - Full with a simultaneous drain: skid moves to main. `in_ready` rises next cycle; there is no accept in this cycle because `in_ready` was 0.
  - One entry with a simultaneous accept and drain: the new word goes straight into main and skid stays empty.

## Test plan
- Reset with XLEN=32, then stream ADDI x1,x0,-1 (0xFFF00093) with `out_ready` = 1 → next cycle: unit 01, alu_op 0000, rd 1, rd_we 1, imm 0xFFFFFFFF; then one word/cycle.
- Hold `out_ready` = 0 while offering 3 words → two are accepted, `in_ready` = 0 after the second, the first word is held stable. Release → words drain in order A, B, then C is accepted.
- XLEN=32: LD (0x00003003) and ADDW (0x0000003B) → illegal = 1, unit 00. XLEN=64: same words → legal; ADDW gives word = 1. LWU is legal; load funct3 111 is illegal.
- SRAI at XLEN=64 (inst[31:26] = 010000, shamt 33) → alu_op 1101, legal. The same word at XLEN=32 → illegal (inst[25] = 1).
- FENCE rw,rw (0x0330000F) → unit 11, pred 0011, succ 0011, rd_we 0. With rd = 1 → illegal.
- `flush` with both entries full plus a concurrent accept → next cycle `out_valid` = 0, `in_ready` = 1, and the flushed words never appear. Repeat with `rst` instead.
